// File: rtl/video_pkg.sv
// Shared video-path constants and types used by the digit tile writer,
// the frame-buffer unit and the HDMI encoder.
package video_pkg;

    localparam int IMG_DIM  = 28;
    localparam int SCALE    = 10;
    localparam int FB_WIDTH = 720;
    localparam int ADDR_W   = 19;
    localparam int ORIGIN_L = 72040;   // row 100, col 40
    localparam int ORIGIN_R = 72400;   // row 100, col 400

    localparam logic [3:0] WE_RGB = 4'b0111;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } tile_state_t;

endpackage

// File: rtl/digit_tile_writer_if.sv
// Pixel-stream handshake and frame-buffer write port of the digit tile writer.
// pix_valid/pix_ready: a pixel transfers on a rising clk edge where both are high;
// pix_ready depends only on writer state, and pix_data is sampled only on that edge.
interface digit_tile_writer_if import video_pkg::*; #(
    parameter int AW = 19
);
    logic           pix_valid;
    logic [7:0]     pix_data;
    logic           pix_ready;
    logic           restart;
    logic [3:0]     we;
    logic [AW-1:0]  addr_w;
    logic [31:0]    data_in;
    logic           side;
    logic           digit_done;
    tile_state_t    state_dbg;

    modport master (
        output pix_valid, pix_data, restart,
        input  pix_ready, we, addr_w, data_in, side, digit_done, state_dbg
    );

    modport slave (
        input  pix_valid, pix_data, restart,
        output pix_ready, we, addr_w, data_in, side, digit_done, state_dbg
    );

endinterface

// File: rtl/block_addr_gen.sv
// Walks one SCALE x SCALE screen block row-major, keeping the frame-buffer
// address incrementally so no multiply sits in the per-write path.
module block_addr_gen #(
    parameter int SCALE    = video_pkg::SCALE,
    parameter int FB_WIDTH = video_pkg::FB_WIDTH,
    parameter int ADDR_W   = video_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] origin_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam int CW = $clog2(SCALE);
    localparam logic [CW-1:0]     C_MAX    = CW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH - (SCALE - 1));

    logic [CW-1:0]     r_q;
    logic [CW-1:0]     c_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
        end else if (clear_i) begin
            r_q <= '0;
            c_q <= '0;
        end else if (load_i) begin
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= origin_i;
        end else if (step_i) begin
            if (c_q != C_MAX) begin
                c_q    <= c_q + 1'b1;
                addr_q <= addr_q + ADDR_W'(1);
            end else begin
                // End of a block row: jump back to column 0 of the next screen row.
                c_q    <= '0;
                r_q    <= (r_q == C_MAX) ? '0 : r_q + 1'b1;
                addr_q <= addr_q + ROW_STEP;
            end
        end
    end

    assign addr_o = addr_q;
    assign last_o = (r_q == C_MAX) && (c_q == C_MAX);

endmodule

// File: rtl/digit_tile_writer.sv
// Turns a 28x28 grayscale digit stream into 10x-upscaled tiles in the frame
// buffer, alternating between a left and a right display slot per digit.
module digit_tile_writer #(
    parameter int IMG_DIM  = video_pkg::IMG_DIM,
    parameter int SCALE    = video_pkg::SCALE,
    parameter int FB_WIDTH = video_pkg::FB_WIDTH,
    parameter int ADDR_W   = video_pkg::ADDR_W,
    parameter int ORIGIN_L = video_pkg::ORIGIN_L,
    parameter int ORIGIN_R = video_pkg::ORIGIN_R
) (
    input  logic               clk,
    input  logic               rst_n,
    digit_tile_writer_if.slave bus
);

    import video_pkg::*;

    localparam int PW = $clog2(IMG_DIM);
    localparam logic [PW-1:0] P_MAX = PW'(IMG_DIM - 1);

    tile_state_t       state_q;
    logic [PW-1:0]     brow_q;
    logic [PW-1:0]     bcol_q;
    logic              side_q;
    logic              done_q;
    logic [3:0]        we_q;
    logic [31:0]       data_q;

    logic              accept;
    logic              step;
    logic              last;
    logic [ADDR_W-1:0] origin;
    logic [ADDR_W-1:0] block_base;
    logic [ADDR_W-1:0] addr;

    assign accept = (state_q == IDLE)  && bus.pix_valid && !bus.restart;
    assign step   = (state_q == WRITE) && !bus.restart;

    // Multiply only once per pixel, at load; the burst itself is incremental.
    assign origin     = side_q ? ADDR_W'(ORIGIN_R) : ADDR_W'(ORIGIN_L);
    assign block_base = origin
                      + ADDR_W'(brow_q) * ADDR_W'(SCALE * FB_WIDTH)
                      + ADDR_W'(bcol_q) * ADDR_W'(SCALE);

    block_addr_gen #(
        .SCALE    (SCALE),
        .FB_WIDTH (FB_WIDTH),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (bus.restart),
        .load_i   (accept),
        .step_i   (step),
        .origin_i (block_base),
        .addr_o   (addr),
        .last_o   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            brow_q  <= '0;
            bcol_q  <= '0;
            side_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= '0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.restart) begin
                // Abort the digit but stay on the same slot.
                state_q <= IDLE;
                we_q    <= '0;
                brow_q  <= '0;
                bcol_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.pix_valid) begin
                            data_q  <= {8'h00, bus.pix_data, bus.pix_data, bus.pix_data};
                            we_q    <= WE_RGB;
                            state_q <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (last) begin
                            state_q <= IDLE;
                            we_q    <= '0;
                            if (bcol_q == P_MAX) begin
                                bcol_q <= '0;
                                if (brow_q == P_MAX) begin
                                    brow_q <= '0;
                                    side_q <= ~side_q;
                                    done_q <= 1'b1;
                                end else begin
                                    brow_q <= brow_q + 1'b1;
                                end
                            end else begin
                                bcol_q <= bcol_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.pix_ready  = (state_q == IDLE);
    assign bus.we         = we_q;
    assign bus.addr_w     = addr;
    assign bus.data_in    = data_q;
    assign bus.side       = side_q;
    assign bus.digit_done = done_q;
    assign bus.state_dbg  = state_q;

endmodule
